// File: rtl/dfx_shim_pkg.sv
// rtl/dfx_shim_pkg.sv - shared FSM state type and counter sizing for dfx_rp_shim
package dfx_shim_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_HOLD  = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_COUPLED   = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DECOUPLED = 3'd4
    } shim_state_e;

    function automatic int cnt_width(input int rst_cycles, input int settle_cycles,
                                     input int drain_timeout);
        int m;
        m = rst_cycles;
        if (settle_cycles > m) m = settle_cycles;
        if (drain_timeout > m) m = drain_timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dfx_axis_gate.sv
// rtl/dfx_axis_gate.sv - per-channel packet tracker and combinational isolation gate
module dfx_axis_gate #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_open,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              o_in_pkt,
    output logic              o_in_pkt_nxt
);

    logic r_in_pkt;
    logic w_accept;

    assign s_tready = i_open & m_tready;
    assign m_tvalid = i_open & s_tvalid;
    assign m_tlast  = i_open & s_tlast;
    assign m_tdata  = i_open ? s_tdata : '0;
    assign w_accept = s_tvalid & s_tready;
    assign o_in_pkt = r_in_pkt;

    // Lookahead value lets the FSM see a tlast accepted this cycle.
    always_comb begin
        o_in_pkt_nxt = r_in_pkt;
        if (w_accept) o_in_pkt_nxt = ~s_tlast;
    end

    always_ff @(posedge clk) begin
        if (!resetn || i_clr) r_in_pkt <= 1'b0;
        else                  r_in_pkt <= o_in_pkt_nxt;
    end

endmodule

// File: rtl/dfx_rp_shim.sv
// rtl/dfx_rp_shim.sv - RP isolation/reset sequencer; DFX_SHIM_TIMEOUT_EN enables drain timeout
module dfx_rp_shim #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 64,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                     clk_in1,
    input  logic                     ext_reset_in,
    input  logic                     decouple_req,
    output logic                     decouple_ack,
    output logic                     rp_reset_n,
    output logic                     rp_ce,
    output logic                     timeout_err,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [NUM_CH*DATA_W-1:0] m_tdata,
    output logic [NUM_CH-1:0]        m_tvalid,
    output logic [NUM_CH-1:0]        m_tlast,
    input  logic [NUM_CH-1:0]        m_tready
);
    import dfx_shim_pkg::*;

    localparam int CNT_W = cnt_width(RST_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT);

    shim_state_e       r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] w_open, w_in_pkt, w_in_pkt_nxt;
    logic              w_clr, w_to_hit;
    logic              r_ack, r_rstn, r_ce;

    assign w_open = (r_state == ST_COUPLED) ? {NUM_CH{1'b1}} :
                    (r_state == ST_DRAIN)   ? w_in_pkt : {NUM_CH{1'b0}};
    assign w_clr  = (w_next == ST_DECOUPLED) || (w_next == ST_RST_HOLD);

`ifdef DFX_SHIM_TIMEOUT_EN
    logic r_terr;
    assign w_to_hit    = (r_cnt == CNT_W'(DRAIN_TIMEOUT - 1));
    assign timeout_err = r_terr;

    // Forced exit from DRAIN with packets still open is the timeout case.
    always_ff @(posedge clk_in1) begin
        if (!ext_reset_in) r_terr <= 1'b0;
        else if (r_state == ST_DRAIN && w_next == ST_DECOUPLED && w_in_pkt_nxt != '0)
            r_terr <= 1'b1;
    end
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST_HOLD:  if (r_cnt == CNT_W'(RST_CYCLES - 1))    w_next = ST_SETTLE;
            ST_SETTLE:    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_next = ST_COUPLED;
            ST_COUPLED:   if (decouple_req)                       w_next = ST_DRAIN;
            ST_DRAIN: begin
                if (w_in_pkt_nxt == '0) w_next = ST_DECOUPLED;
                else if (!decouple_req) w_next = ST_COUPLED;
                else if (w_to_hit)      w_next = ST_DECOUPLED;
            end
            ST_DECOUPLED: if (!decouple_req) w_next = ST_RST_HOLD;
            default:      w_next = ST_RST_HOLD;
        endcase
    end

    always_ff @(posedge clk_in1) begin
        if (!ext_reset_in) begin
            r_state <= ST_RST_HOLD;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
            r_rstn  <= 1'b0;
            r_ce    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            r_ack   <= (w_next == ST_RST_HOLD) || (w_next == ST_DECOUPLED);
            r_rstn  <= !((w_next == ST_RST_HOLD) || (w_next == ST_DECOUPLED));
            r_ce    <= (w_next != ST_DECOUPLED);
        end
    end

    assign decouple_ack = r_ack;
    assign rp_reset_n   = r_rstn;
    assign rp_ce        = r_ce;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dfx_axis_gate #(.DATA_W(DATA_W)) u_gate (
            .clk          (clk_in1),
            .resetn       (ext_reset_in),
            .i_open       (w_open[g]),
            .i_clr        (w_clr),
            .s_tdata      (s_tdata[g*DATA_W +: DATA_W]),
            .s_tvalid     (s_tvalid[g]),
            .s_tlast      (s_tlast[g]),
            .s_tready     (s_tready[g]),
            .m_tdata      (m_tdata[g*DATA_W +: DATA_W]),
            .m_tvalid     (m_tvalid[g]),
            .m_tlast      (m_tlast[g]),
            .m_tready     (m_tready[g]),
            .o_in_pkt     (w_in_pkt[g]),
            .o_in_pkt_nxt (w_in_pkt_nxt[g])
        );
    end

endmodule

// File: tb/tb_dfx_rp_shim.sv
// tb/tb_dfx_rp_shim.sv - directed and randomized checks of dfx_rp_shim against a phase model
module tb_dfx_rp_shim;

    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int RST = 16;
    localparam int STL = 2;
    localparam int DTO = 8;
`ifdef DFX_SHIM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_HOLD = 0, P_SETTLE = 1, P_COUPLED = 2, P_DRAIN = 3, P_DEC = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic req = 1'b0;
    logic [NCH*DW-1:0] s_tdata = '0;
    logic [NCH-1:0] s_tvalid = '0, s_tlast = '0, m_tready = '1;
    logic decouple_ack, rp_reset_n, rp_ce, timeout_err;
    logic [NCH-1:0] s_tready, m_tvalid, m_tlast;
    logic [NCH*DW-1:0] m_tdata;

    always #5 clk = ~clk;

    dfx_rp_shim #(
        .NUM_CH(NCH), .DATA_W(DW), .RST_CYCLES(RST),
        .SETTLE_CYCLES(STL), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk_in1(clk), .ext_reset_in(rstn), .decouple_req(req),
        .decouple_ack(decouple_ack), .rp_reset_n(rp_reset_n), .rp_ce(rp_ce),
        .timeout_err(timeout_err),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: current phase, cycles spent in it, open packets, sticky error.
    int ph = P_HOLD;
    int t  = 0;
    logic [NCH-1:0] pk = '0;
    logic terr_m = 1'b0;
    logic [NCH-1:0] acc_m;

    logic smp_ack, smp_rstn, smp_ce, smp_terr;
    logic [NCH-1:0] smp_stready, smp_mtvalid;

    task automatic step();
        logic [NCH-1:0] op, ex_tr, acc, pk_n;
        logic [NCH*DW-1:0] ex_d;
        int ph_n, t_n;
        logic terr_n;
        @(negedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            op[i] = (ph == P_COUPLED) || (ph == P_DRAIN && pk[i]);
            ex_d[i*DW +: DW] = op[i] ? s_tdata[i*DW +: DW] : '0;
        end
        ex_tr = op & m_tready;
        check_eq("m_tvalid", m_tvalid, op & s_tvalid);
        check_eq("s_tready", s_tready, ex_tr);
        check_eq("m_tdata", m_tdata, ex_d);
        check_eq("m_tlast", m_tlast & op, s_tlast & op);
        check_eq("decouple_ack", decouple_ack, (ph == P_HOLD) || (ph == P_DEC));
        check_eq("rp_reset_n", rp_reset_n, !((ph == P_HOLD) || (ph == P_DEC)));
        check_eq("rp_ce", rp_ce, ph != P_DEC);
        check_eq("timeout_err", timeout_err, terr_m);
        smp_ack = decouple_ack; smp_rstn = rp_reset_n; smp_ce = rp_ce;
        smp_terr = timeout_err; smp_stready = s_tready; smp_mtvalid = m_tvalid;

        if (!rstn) begin
            ph_n = P_HOLD; t_n = 0; pk_n = '0; terr_n = 1'b0; acc = '0;
        end else begin
            acc = s_tvalid & ex_tr;
            pk_n = pk;
            for (int i = 0; i < NCH; i++) if (acc[i]) pk_n[i] = !s_tlast[i];
            ph_n = ph;
            terr_n = terr_m;
            case (ph)
                P_HOLD:    if (t + 1 >= RST) ph_n = P_SETTLE;
                P_SETTLE:  if (t + 1 >= STL) ph_n = P_COUPLED;
                P_COUPLED: if (req) ph_n = P_DRAIN;
                P_DRAIN: begin
                    if (pk_n == '0) ph_n = P_DEC;
                    else if (!req) ph_n = P_COUPLED;
                    else if (TO_EN && t + 1 >= DTO) begin ph_n = P_DEC; terr_n = 1'b1; end
                end
                default:   if (!req) ph_n = P_HOLD;
            endcase
            t_n = (ph_n == ph) ? t + 1 : 0;
            if (ph_n != ph && (ph_n == P_DEC || ph_n == P_HOLD)) pk_n = '0;
        end
        @(posedge clk);
        ph = ph_n; t = t_n; pk = pk_n; terr_m = terr_n; acc_m = acc;
        #1;
    endtask

    task automatic wait_phase(input int p, input string tag);
        for (int k = 0; k < 200 && ph != p; k++) step();
        if (ph != p) check_eq(tag, ph, p);
    endtask

    int n, beats;

    initial begin
        repeat (3) step();

        // Reset release: hold length, then settle length.
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin step(); if (smp_rstn) break; n++; end
        check_eq("rst_hold_len", n, RST);
        check_eq("ack_low_at_settle", smp_ack, 0);
        n = 1;
        for (int k = 0; k < 10; k++) begin step(); if (smp_stready != 0) break; n++; end
        check_eq("settle_len", n, STL);

        // Idle decouple.
        req = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); if (smp_ack) break; n++; end
        check_eq("idle_ack_latency", n, 2);
        check_eq("decoupled_stready", smp_stready, 0);
        check_eq("decoupled_ce", smp_ce, 0);

        // Re-couple latency to first m_tvalid.
        s_tvalid = 2'b11; s_tlast = 2'b00; req = 1'b0;
        n = 0;
        for (int k = 0; k < 60; k++) begin step(); if (smp_mtvalid != 0) break; n++; end
        check_eq("recouple_latency", n, 1 + RST + STL);
        s_tlast = 2'b11; step();

        // Mid-packet drain on ch0, new packet on ch1 blocked.
        s_tvalid = 2'b01; s_tlast = 2'b00; s_tdata = 32'h1234_abcd; step();
        req = 1'b1; s_tvalid = 2'b00; step();
        s_tvalid = 2'b11; m_tready = 2'b10;
        beats = 1;
        for (int k = 0; k < 20 && beats < 4; k++) begin
            s_tlast = {1'b0, beats == 3};
            m_tready[0] = k[0];
            s_tdata = $urandom;
            step();
            check_eq("ch1_blocked", smp_stready[1], 0);
            if (acc_m[0]) beats++;
        end
        check_eq("drain_beats", beats, 4);
        s_tvalid = 2'b00; s_tlast = 2'b00; step();
        check_eq("ack_after_tlast", smp_ack, 1);

        // Abort a drain: req drops before tlast.
        m_tready = 2'b11; req = 1'b0;
        wait_phase(P_COUPLED, "wait_coupled_abort");
        s_tvalid = 2'b01; step();
        req = 1'b1; s_tvalid = 2'b00; step();
        m_tready = 2'b00; s_tvalid = 2'b01; step();
        req = 1'b0; step();
        m_tready = 2'b11; s_tvalid = 2'b00; step();
        check_eq("abort_rstn", smp_rstn, 1);
        check_eq("abort_coupled", smp_stready, 2'b11);
        s_tvalid = 2'b01; s_tlast = 2'b01; step();
        s_tvalid = 2'b00; s_tlast = 2'b00;

`ifdef DFX_SHIM_TIMEOUT_EN
        // Stalled drain times out.
        s_tvalid = 2'b01; step();
        req = 1'b1; m_tready = 2'b00; step();
        n = 0;
        for (int k = 0; k < 30; k++) begin step(); if (smp_ack) break; n++; end
        check_eq("timeout_len", n, DTO);
        check_eq("timeout_err_set", smp_terr, 1);
        req = 1'b0; m_tready = 2'b11; s_tvalid = 2'b00;
        wait_phase(P_COUPLED, "wait_coupled_to");
        step();
        check_eq("timeout_err_sticky", smp_terr, 1);
`endif

        // Reset in the middle of a drain.
        s_tvalid = 2'b01; s_tlast = 2'b00; step();
        req = 1'b1; m_tready = 2'b00; step();
        rstn = 1'b0; step();
        step();
        check_eq("rst_mid_ack", smp_ack, 1);
        check_eq("rst_mid_rstn", smp_rstn, 0);
        check_eq("rst_mid_ce", smp_ce, 1);
        check_eq("rst_mid_stready", smp_stready, 0);
        check_eq("rst_mid_terr", smp_terr, 0);
        rstn = 1'b1; req = 1'b0; s_tvalid = 2'b00; m_tready = 2'b11;
        wait_phase(P_COUPLED, "wait_coupled_rst");
        req = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); if (smp_ack) break; n++; end
        check_eq("pkt_cleared_by_reset", n, 2);
        req = 1'b0;

        // Randomized traffic, requests and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) req = ~req;
            rstn = ($urandom_range(0, 599) != 0);
            s_tvalid = NCH'($urandom);
            for (int i = 0; i < NCH; i++) begin
                s_tlast[i]  = ($urandom_range(0, 3) == 0);
                m_tready[i] = ($urandom_range(0, 3) != 0);
            end
            s_tdata = NCH*DW'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
